mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory bus between instruction fetch (pc/instr side) and
//  load/store data access (regfile/alu side) of the rv32i core. Arbitrates, registers
//  the selected request onto the bus, waits for mem_ack, and returns data with a
//  one-cycle valid pulse. Bus timeout watchdog: a hung access cannot deadlock the core.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  TIMEOUT     15  max cycles in a bus phase waiting for mem_ack (>=1)
//  STARVE_MAX  4   consecutive lost arbitrations before fetch is forced (fair mode only)
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-high reset
//  if_req     in   1         fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W    fetch address
//  if_gnt     out  1         1-cycle pulse: fetch accepted
//  if_valid   out  1         1-cycle pulse: fetch done, if_rdata/if_err valid
//  if_rdata   out  DATA_W    fetched instruction
//  if_err     out  1         fetch timed out (qualified by if_valid)
//  d_req      in   1         data request; held with d_* until d_gnt
//  d_we       in   1         1 = store, 0 = load
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    store data
//  d_wstrb    in   DATA_W/8  store byte enables
//  d_gnt      out  1         1-cycle pulse: data access accepted
//  d_valid    out  1         1-cycle pulse: data access done
//  d_rdata    out  DATA_W    load data (0 for stores)
//  d_err      out  1         data access timed out (qualified by d_valid)
//  mem_req    out  1         bus request, held until mem_ack or timeout
//  mem_we     out  1         bus write
//  mem_addr   out  ADDR_W    bus address
//  mem_wdata  out  DATA_W    bus write data
//  mem_wstrb  out  DATA_W/8  bus byte enables (0 on reads)
//  mem_ack    in   1         bus completion; mem_rdata valid same cycle
//  mem_rdata  in   DATA_W    bus read data
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output 0, counters 0.
//  - FSM: IDLE -> IF_BUS | D_BUS -> IDLE.
//  - IDLE: if any req, pick winner; that cycle's edge loads mem_* from winner,
//    pulses its *_gnt, enters *_BUS. No req: stay IDLE, mem_req=0.
//  - Priority: d_req beats if_req (data access belongs to the older instruction).
//  - *_BUS: mem_req=1, mem_* stable. On mem_ack: latch mem_rdata (d_rdata=0 if
//    mem_we), pulse *_valid with *_err=0, drop mem_req, go IDLE. No back-to-back:
//    next grant no earlier than the cycle after valid.
//  - Latency: req sampled cycle N -> gnt & mem_req from N+1 -> ack at N+1+k (k>=0)
//    -> valid at N+2+k. Min 2 cycles req-to-valid.
//  - Timeout: wait counter clears on entry, increments each cycle without ack;
//    ack absent when counter==TIMEOUT-1 -> drop mem_req, pulse valid, err=1,
//    rdata=0, go IDLE. Ack in that same cycle wins (normal completion).
//  - Requester dropping req before gnt: allowed, nothing issued. Req during BUS
//    phase waits. A late mem_ack in IDLE is ignored.
//  - Reset mid-access: immediate IDLE, mem_req=0, no valid pulse.
// CONFIGURATION
//  MEM_ARB_FAIR_EN defined: starve counter counts IDLE grants to data while
//    if_req=1; reaching STARVE_MAX, next arbitration goes to fetch even if d_req=1;
//    counter clears on any fetch grant or when if_req=0 at arbitration.
//  Undefined: strict data priority; fetch may starve indefinitely; no counter logic.
// TESTING
//  1 Fetch only: if_req, if_addr=0x100, ack 2 cycles later, rdata=0x00500093 ->
//    if_gnt at N+1, mem_addr=0x100, if_valid at N+4, if_rdata=0x00500093, if_err=0.
//  2 Both req same cycle, d_we=1 addr=0x2000 wdata=0xDEADBEEF wstrb=0xF, ack k=0 ->
//    data first, mem_we=1; d_valid, d_rdata=0; fetch granted the cycle after d_valid.
//  3 Timeout: d_req load, never ack, TIMEOUT=15 -> mem_req high 15 cycles then 0;
//    d_valid with d_err=1, d_rdata=0; fresh req afterwards completes normally.
//  4 Ack on final timeout cycle -> normal completion, err=0, rdata returned.
//  5 Reset asserted while mem_req=1 -> all outputs 0 asynchronously, no valid
//    after release; stale mem_ack in IDLE ignored.
//  6 MEM_ARB_FAIR_EN, STARVE_MAX=4, d_req and if_req both continuously high ->
//    grants D,D,D,D,IF,D,...; without the macro fetch never granted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the load/store port and the shared memory bus
//   that mem_port_arbiter sits between.
//   modport master : the arbiter (samples requests, drives grants/results and the bus)
//   modport slave  : the environment (fetch unit, load/store unit and memory)
//   Signals:
//     if_req/if_addr            -> fetch request, held until if_gnt
//     if_gnt/if_valid/if_rdata/if_err <- fetch grant and completion
//     d_req/d_we/d_addr/d_wdata/d_wstrb -> data request, held until d_gnt
//     d_gnt/d_valid/d_rdata/d_err      <- data grant and completion
//     mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb <- bus request
//     mem_ack/mem_rdata         -> bus completion
//     busy                      <- arbiter is in a bus phase
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_valid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_err;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_valid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_valid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata,
        output busy
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_valid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory bus between instruction fetch and
//   load/store. One access at a time: arbitrate in IDLE, hold the winner's
//   request on the bus until mem_ack or the wait watchdog expires, then pulse
//   the winner's valid with the returned data (or err=1 on timeout).
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high
//     bus    mem_port_arbiter_if.master (fetch port, data port, memory bus, busy)
//   Parameters: ADDR_W, DATA_W, TIMEOUT (bus-phase cycles before giving up, >=1),
//     STARVE_MAX (consecutive data wins before fetch is forced).
//   Build option: define MEM_ARB_FAIR_EN to enable the fetch anti-starvation
//     counter; without it data always wins and fetch may starve.
//
//   state    | meaning
//   S_IDLE   | no access in flight; arbitrate any pending request
//   S_IF_BUS | fetch on the bus, waiting for mem_ack or timeout
//   S_D_BUS  | load/store on the bus, waiting for mem_ack or timeout
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    if (TIMEOUT < 1 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: TIMEOUT and STARVE_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IF_BUS = 2'd1,
        S_D_BUS  = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      wait_cnt_q;

    logic                  if_gnt_q;
    logic                  if_valid_q;
    logic [DATA_W-1:0]     if_rdata_q;
    logic                  if_err_q;
    logic                  d_gnt_q;
    logic                  d_valid_q;
    logic [DATA_W-1:0]     d_rdata_q;
    logic                  d_err_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [DATA_W/8-1:0]   mem_wstrb_q;
    logic                  busy_q;

    logic                  force_if;
    logic                  take_d;
    logic                  phase_done;
    logic [DATA_W-1:0]     ret_data;

`ifdef MEM_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0]         starve_q;

    assign force_if = bus.if_req && (starve_q >= SW'(STARVE_MAX));
`else
    assign force_if = 1'b0;
`endif

    assign take_d     = bus.d_req && !force_if;
    // An ack in the last allowed cycle still counts as a normal completion.
    assign phase_done = bus.mem_ack || (wait_cnt_q == WAIT_LAST);
    // Stores and timeouts return zero data.
    assign ret_data   = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            if_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            starve_q    <= '0;
`endif
        end else begin
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (take_d) begin
                        state_q     <= S_D_BUS;
                        d_gnt_q     <= 1'b1;
                        mem_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        wait_cnt_q  <= '0;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_we ? bus.d_wdata : '0;
                        mem_wstrb_q <= bus.d_we ? bus.d_wstrb : '0;
                    end else if (bus.if_req) begin
                        state_q     <= S_IF_BUS;
                        if_gnt_q    <= 1'b1;
                        mem_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        wait_cnt_q  <= '0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                    end
`ifdef MEM_ARB_FAIR_EN
                    // Count only data wins that made a waiting fetch lose.
                    if (bus.if_req || bus.d_req) begin
                        starve_q <= (take_d && bus.if_req) ? starve_q + SW'(1) : '0;
                    end
`endif
                end
                S_IF_BUS, S_D_BUS: begin
                    if (phase_done) begin
                        state_q    <= S_IDLE;
                        mem_req_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        wait_cnt_q <= '0;
                        if (state_q == S_IF_BUS) begin
                            if_valid_q <= 1'b1;
                            if_err_q   <= !bus.mem_ack;
                            if_rdata_q <= ret_data;
                        end else begin
                            d_valid_q  <= 1'b1;
                            d_err_q    <= !bus.mem_ack;
                            d_rdata_q  <= ret_data;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by random fetch/data/memory traffic, all
//   compared cycle by cycle against a transaction-level reference model.
//   Honours MEM_ARB_FAIR_EN the same way as the design.
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 15;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 none, 1 fetch, 2 data; phase = bus cycles observed so far.
    int          m_owner, m_phase, m_starve;
    logic        e_mem_req, e_busy, e_mem_we;
    logic        e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_if_err, e_d_err;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
    logic [3:0]  e_mem_wstrb;

    logic        p_rst, p_if_req, p_d_req, p_d_we, p_ack;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata, p_rdata;
    logic [3:0]  p_d_wstrb;

    task automatic model_reset();
        m_owner = 0; m_phase = 0; m_starve = 0;
        e_mem_req = 0; e_busy = 0; e_mem_we = 0;
        e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0;
        e_if_err = 0; e_d_err = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
        e_mem_wstrb = 0;
    endtask

    task automatic model_step();
        bit fetch_wins;
        if (p_rst) begin
            model_reset();
            return;
        end
        e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0;
        if (m_owner == 0) begin
            if (p_d_req || p_if_req) begin
                fetch_wins = !p_d_req || (FAIR && p_if_req && m_starve >= STARVE_MAX);
                m_starve = (fetch_wins || !p_if_req) ? 0 : m_starve + 1;
                m_owner = fetch_wins ? 1 : 2;
                m_phase = 0;
                e_mem_req = 1; e_busy = 1;
                if (fetch_wins) begin
                    e_if_gnt = 1; e_mem_we = 0; e_mem_addr = p_if_addr; e_mem_wstrb = 0;
                end else begin
                    e_d_gnt = 1; e_mem_we = p_d_we; e_mem_addr = p_d_addr;
                    e_mem_wdata = p_d_wdata; e_mem_wstrb = p_d_we ? p_d_wstrb : 4'h0;
                end
            end
        end else begin
            m_phase++;
            if (p_ack || m_phase == TIMEOUT) begin
                e_mem_req = 0; e_busy = 0;
                if (m_owner == 1) begin
                    e_if_valid = 1; e_if_err = !p_ack;
                    e_if_rdata = p_ack ? p_rdata : 32'h0;
                end else begin
                    e_d_valid = 1; e_d_err = !p_ack;
                    e_d_rdata = (p_ack && !e_mem_we) ? p_rdata : 32'h0;
                end
                m_owner = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_val("mem_req", bus.mem_req, e_mem_req);
        check_val("busy", bus.busy, e_busy);
        check_val("if_gnt", bus.if_gnt, e_if_gnt);
        check_val("d_gnt", bus.d_gnt, e_d_gnt);
        check_val("if_valid", bus.if_valid, e_if_valid);
        check_val("d_valid", bus.d_valid, e_d_valid);
        if (e_mem_req) begin
            check_val("mem_addr", bus.mem_addr, e_mem_addr);
            check_val("mem_we", bus.mem_we, e_mem_we);
            check_val("mem_wstrb", bus.mem_wstrb, e_mem_wstrb);
            if (e_mem_we) check_val("mem_wdata", bus.mem_wdata, e_mem_wdata);
        end
        if (e_if_valid) begin
            check_val("if_rdata", bus.if_rdata, e_if_rdata);
            check_val("if_err", bus.if_err, e_if_err);
        end
        if (e_d_valid) begin
            check_val("d_rdata", bus.d_rdata, e_d_rdata);
            check_val("d_err", bus.d_err, e_d_err);
        end
    endtask

    // Advance one clock: capture what the edge will sample, then check at negedge.
    task automatic cycle();
        p_rst = reset; p_if_req = bus.if_req; p_if_addr = bus.if_addr;
        p_d_req = bus.d_req; p_d_we = bus.d_we; p_d_addr = bus.d_addr;
        p_d_wdata = bus.d_wdata; p_d_wstrb = bus.d_wstrb;
        p_ack = bus.mem_ack; p_rdata = bus.mem_rdata;
        @(negedge clk);
        model_step();
        compare_all();
    endtask

    task automatic clear_inputs();
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    bit hang;

    task automatic drive_random();
        if (bus.if_gnt) bus.if_req = 0;
        if (!bus.if_req) begin
            if ($urandom_range(99) < 30) begin
                bus.if_req = 1;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
        end else if ($urandom_range(99) < 3) begin
            bus.if_req = 0;
        end
        if (bus.d_gnt) bus.d_req = 0;
        if (!bus.d_req) begin
            if ($urandom_range(99) < 30) begin
                bus.d_req = 1;
                bus.d_we = 1'($urandom_range(1));
                bus.d_addr = $urandom;
                bus.d_wdata = $urandom;
                bus.d_wstrb = 4'($urandom_range(15, 1));
            end
        end else if ($urandom_range(99) < 3) begin
            bus.d_req = 0;
        end
        if (bus.if_gnt || bus.d_gnt) hang = ($urandom_range(99) < 10);
        if (bus.mem_req) bus.mem_ack = !hang && ($urandom_range(99) < 35);
        else bus.mem_ack = ($urandom_range(99) < 5);
        bus.mem_rdata = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;
        int ngr;
        int got_seq[10];

        model_reset();
        clear_inputs();
        #1;
        check_val("rst_mem_req", bus.mem_req, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_valids", {bus.if_valid, bus.d_valid, bus.if_gnt, bus.d_gnt}, 0);
        do_reset();

        // 1: fetch only, ack two cycles after grant
        bus.if_req = 1; bus.if_addr = 32'h100;
        cycle();
        check_val("t1_gnt", bus.if_gnt, 1);
        check_val("t1_addr", bus.mem_addr, 32'h100);
        bus.if_req = 0;
        cycle();
        cycle();
        bus.mem_ack = 1; bus.mem_rdata = 32'h0050_0093;
        cycle();
        check_val("t1_valid", bus.if_valid, 1);
        check_val("t1_rdata", bus.if_rdata, 32'h0050_0093);
        check_val("t1_err", bus.if_err, 0);
        bus.mem_ack = 0;
        cycle();

        // 2: simultaneous requests, data store wins, fetch follows after d_valid
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
        bus.if_req = 1; bus.if_addr = 32'h104;
        cycle();
        check_val("t2_dgnt", bus.d_gnt, 1);
        check_val("t2_ifgnt", bus.if_gnt, 0);
        check_val("t2_we", bus.mem_we, 1);
        check_val("t2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.d_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h1111_1111;
        cycle();
        check_val("t2_dvalid", bus.d_valid, 1);
        check_val("t2_drdata", bus.d_rdata, 0);
        bus.mem_ack = 0;
        cycle();
        check_val("t2_ifgnt_after", bus.if_gnt, 1);
        check_val("t2_ifaddr", bus.mem_addr, 32'h104);
        bus.if_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0013;
        cycle();
        check_val("t2_ifvalid", bus.if_valid, 1);
        bus.mem_ack = 0;
        cycle();

        // 3: load that never gets an ack
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        cycle();
        bus.d_req = 0;
        cnt = bus.mem_req ? 1 : 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (bus.d_valid) begin
                seen = 1;
                break;
            end
            if (bus.mem_req) cnt++;
        end
        check_val("t3_valid_seen", seen, 1);
        check_val("t3_req_cycles", cnt, TIMEOUT);
        check_val("t3_err", bus.d_err, 1);
        check_val("t3_rdata", bus.d_rdata, 0);
        bus.d_req = 1; bus.d_addr = 32'h44;
        cycle();
        bus.d_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_F00D;
        cycle();
        check_val("t3_fresh_valid", bus.d_valid, 1);
        check_val("t3_fresh_err", bus.d_err, 0);
        check_val("t3_fresh_rdata", bus.d_rdata, 32'hCAFE_F00D);
        bus.mem_ack = 0;
        cycle();

        // 4: ack lands in the last allowed bus cycle
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h48;
        cycle();
        bus.d_req = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) cycle();
        check_val("t4_req_last", bus.mem_req, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
        cycle();
        check_val("t4_valid", bus.d_valid, 1);
        check_val("t4_err", bus.d_err, 0);
        check_val("t4_rdata", bus.d_rdata, 32'h1234_5678);
        bus.mem_ack = 0;
        cycle();

        // 5: reset in the middle of an access, then a stale ack
        bus.d_req = 1; bus.d_addr = 32'h80;
        cycle();
        bus.d_req = 0;
        cycle();
        #2 reset = 1;
        #1;
        check_val("t5_mem_req", bus.mem_req, 0);
        check_val("t5_busy", bus.busy, 0);
        check_val("t5_addr", bus.mem_addr, 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'h5555_AAAA;
        cycle();
        reset = 0;
        cycle();
        bus.mem_ack = 0;
        cycle();
        check_val("t5_no_valid", {bus.d_valid, bus.if_valid}, 0);
        check_val("t5_idle", bus.mem_req, 0);

        // 6: both requesters permanently asserting
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        ngr = 0;
        for (int i = 0; i < 10; i++) got_seq[i] = 0;
        for (int i = 0; i < 200 && ngr < 10; i++) begin
            cycle();
            if (bus.d_gnt) got_seq[ngr++] = 2;
            else if (bus.if_gnt) got_seq[ngr++] = 1;
            bus.mem_ack = bus.mem_req;
            bus.mem_rdata = $urandom;
        end
        check_val("t6_count", ngr, 10);
        for (int i = 0; i < 10; i++)
            check_val($sformatf("t6_grant%0d", i), got_seq[i], (FAIR && (i % 5 == 4)) ? 1 : 2);

        // random traffic
        do_reset();
        hang = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            drive_random();
        end
        clear_inputs();
        for (int i = 0; i < 2 * TIMEOUT; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
